// File: rtl/stat_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stat_cnt_pkg
// Description : Shared types and helpers for the statistics counter store.
//               Holds the pipeline op record, the depth helper and the
//               saturating / wrapping adder used by the update stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stat_cnt_pkg;

    // Widest supported counter index and counter; the op record is sized to
    // these and narrowed with casts inside the parametrised modules.
    localparam int MAX_ADDR_W = 10;
    localparam int MAX_CNT_W  = 64;

    // One pipeline operation: increment and/or read (with optional clear).
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_CNT_W-1:0]  inc;
        logic                  rd;
        logic                  clr;
        logic                  vld;
    } op_t;

    // Number of counters for a given index width.
    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    // Adds two width-bit values (held zero-extended in 64 bits). With sat set
    // the result clamps to all-ones on carry out, otherwise it wraps.
    function automatic logic [MAX_CNT_W-1:0] sat_add(
        input logic [MAX_CNT_W-1:0] a,
        input logic [MAX_CNT_W-1:0] b,
        input int                   width,
        input logic                 sat
    );
        logic [MAX_CNT_W:0]   sum;
        logic [MAX_CNT_W-1:0] mask;
        // A shift by the full 64 bits yields zero, so mask is all-ones then.
        mask = ~({MAX_CNT_W{1'b1}} << width);
        sum  = {1'b0, a} + {1'b0, b};
        if (sat && sum[width]) begin
            return mask;
        end
        return sum[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stat_cnt_mem.sv
`default_nettype none
// ============================================================================
// Module      : stat_cnt_mem
// Description : Simple dual-port distributed RAM for the counter array.
//               Asynchronous read, synchronous write, no reset on contents.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_cnt_mem
    import stat_cnt_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [CNT_WIDTH-1:0]  wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [CNT_WIDTH-1:0]  rdata_o
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    logic [CNT_WIDTH-1:0] mem_q [0:DEPTH-1];

    // Single write port shared by the init sweep and the update stage.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/stat_cnt_ram.sv
`default_nettype none
// ============================================================================
// Module      : stat_cnt_ram
// Description : Statistics counter store. One increment or read per cycle
//               through a two-edge read-modify-write pipeline with a
//               same-index bypass; optional clear-on-read and saturation.
//               Zeroes every entry after reset before accepting traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_cnt_ram
    import stat_cnt_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int INC_WIDTH  = 16,
    parameter int SATURATE   = 0,
    parameter int CLR_ON_RD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_vld,
    input  logic [ADDR_WIDTH-1:0] inc_addr,
    input  logic [INC_WIDTH-1:0]  inc_val,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rdy,
    output logic                  rd_vld,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  init_busy
);

    localparam int                    DEPTH    = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    init_state_e           state_q;
    logic [ADDR_WIDTH-1:0] init_ptr_q;
    logic                  init_busy_q;

    op_t                   op_d;
    op_t                   op_q;
    logic [CNT_WIDTH-1:0]  operand_d;
    logic [CNT_WIDTH-1:0]  operand_q;
    logic                  rd_vld_q;
    logic [CNT_WIDTH-1:0]  rd_data_q;

    logic                  w_inc_ok;
    logic                  w_rd_ok;
    logic                  w_rd_rdy;
    logic                  w_bypass;
    logic [CNT_WIDTH-1:0]  w_base;
    logic [CNT_WIDTH-1:0]  w_new;
    logic [CNT_WIDTH-1:0]  w_mem_rdata;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [CNT_WIDTH-1:0]  w_mem_wdata;

    // Init sweep: zero one entry per cycle, then hand the RAM to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + ADDR_WIDTH'(1);
                    if (init_ptr_q == LAST_IDX) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Op formation: the increment always wins; a read to another index waits.
    always_comb begin
        w_inc_ok  = inc_vld & ~init_busy_q;
        w_rd_rdy  = ~init_busy_q & (~inc_vld | (inc_addr == rd_addr));
        w_rd_ok   = rd_req & w_rd_rdy;
        op_d      = '0;
        op_d.vld  = w_inc_ok | w_rd_ok;
        op_d.addr = MAX_ADDR_W'(w_inc_ok ? inc_addr : rd_addr);
        op_d.inc  = w_inc_ok ? MAX_CNT_W'(inc_val) : '0;
        op_d.rd   = w_rd_ok;
        op_d.clr  = w_rd_ok & (CLR_ON_RD != 0);
    end

    // Update value for the op in S1; the bypass feeds it to a same-index
    // successor because the RAM write lands only on the next edge.
    always_comb begin
        w_base    = op_q.clr ? '0 : operand_q;
        w_new     = CNT_WIDTH'(sat_add(MAX_CNT_W'(w_base), op_q.inc,
                                       CNT_WIDTH, SATURATE != 0));
        w_bypass  = op_q.vld & (op_q.addr == op_d.addr);
        operand_d = w_bypass ? w_new : w_mem_rdata;
    end

    // S1: capture the op and its current counter value.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else begin
            op_q <= op_d;
        end
        operand_q <= operand_d;
    end

    // Read-out: return the value seen before this op's clear or increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= op_q.vld & op_q.rd;
            if (op_q.vld & op_q.rd) begin
                rd_data_q <= operand_q;
            end
        end
    end

    // The sweep and the pipeline are mutually exclusive in time.
    assign w_mem_we    = (init_busy_q | op_q.vld) & ~rst;
    assign w_mem_waddr = init_busy_q ? init_ptr_q : ADDR_WIDTH'(op_q.addr);
    assign w_mem_wdata = init_busy_q ? '0 : w_new;

    stat_cnt_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_mem_we),
        .waddr_i (w_mem_waddr),
        .wdata_i (w_mem_wdata),
        .raddr_i (ADDR_WIDTH'(op_d.addr)),
        .rdata_o (w_mem_rdata)
    );

    assign rd_rdy    = w_rd_rdy;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;
    assign init_busy = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stat_cnt_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_stat_cnt_ram
// Description : Self-checking bench. Three instances share one stimulus
//               stream: 64-bit wrapping, 8-bit saturating, 8-bit wrapping.
//               A reference model predicts every read; expectations are
//               queued at acceptance and retired when rd_vld is due.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stat_cnt_ram;

    typedef struct {
        logic [63:0] e64;
        logic [7:0]  es;
        logic [7:0]  ew;
        int          cyc;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        inc_vld  = 1'b0;
    logic [3:0]  inc_addr = '0;
    logic [15:0] inc_val  = '0;
    logic        rd_req   = 1'b0;
    logic [3:0]  rd_addr  = '0;

    logic        rd_rdy, rd_vld, init_busy;
    logic [63:0] rd_data;
    logic        rd_rdy_s, rd_vld_s, init_busy_s;
    logic [7:0]  rd_data_s;
    logic        rd_rdy_w, rd_vld_w, init_busy_w;
    logic [7:0]  rd_data_w;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic        tb_run   = 1'b0;
    logic [63:0] m64 [16];
    logic [7:0]  ms  [16];
    logic [7:0]  mw  [16];
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic        mon_v;
    logic [63:0] last_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stat_cnt_ram #(.ADDR_WIDTH(4), .CNT_WIDTH(64), .INC_WIDTH(16), .SATURATE(0), .CLR_ON_RD(1)) u_dut (
        .clk(clk), .rst(rst), .inc_vld(inc_vld), .inc_addr(inc_addr), .inc_val(inc_val),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .rd_vld(rd_vld),
        .rd_data(rd_data), .init_busy(init_busy));

    stat_cnt_ram #(.ADDR_WIDTH(4), .CNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(1), .CLR_ON_RD(1)) u_sat (
        .clk(clk), .rst(rst), .inc_vld(inc_vld), .inc_addr(inc_addr), .inc_val(inc_val[7:0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy_s), .rd_vld(rd_vld_s),
        .rd_data(rd_data_s), .init_busy(init_busy_s));

    stat_cnt_ram #(.ADDR_WIDTH(4), .CNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(0), .CLR_ON_RD(1)) u_wrap (
        .clk(clk), .rst(rst), .inc_vld(inc_vld), .inc_addr(inc_addr), .inc_val(inc_val[7:0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy_w), .rd_vld(rd_vld_w),
        .rd_data(rd_data_w), .init_busy(init_busy_w));

    function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Scoreboard: rd_vld must appear exactly when the queue head is due.
    always @(negedge clk) begin
        if (rst) begin
            last_data = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
            mon_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            n_checks++;
            if (rd_vld !== mon_v || rd_vld_s !== mon_v || rd_vld_w !== mon_v) begin
                n_errors++;
                $display("FAIL rd_vld cyc %0d: got %b/%b/%b expected %b",
                         cyc, rd_vld, rd_vld_s, rd_vld_w, mon_v);
            end
            if (mon_v) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (rd_data !== mon_e.e64 || rd_data_s !== mon_e.es || rd_data_w !== mon_e.ew) begin
                    n_errors++;
                    $display("FAIL rd_data cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             cyc, rd_data, rd_data_s, rd_data_w, mon_e.e64, mon_e.es, mon_e.ew);
                end
                last_data = mon_e.e64;
            end else begin
                n_checks++;
                if (rd_data !== last_data) begin
                    n_errors++;
                    $display("FAIL rd_data_hold cyc %0d: got %0d expected %0d", cyc, rd_data, last_data);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m64[i] = '0; ms[i] = '0; mw[i] = '0;
        end
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, check rd_rdy, update the model.
    task automatic do_op(input logic iv, input logic [3:0] ia, input logic [15:0] ival,
                         input logic rr, input logic [3:0] ra);
        logic exp_rdy;
        exp_t e;
        inc_vld = iv; inc_addr = ia; inc_val = ival; rd_req = rr; rd_addr = ra;
        #1;
        exp_rdy = tb_run && (!iv || ia == ra);
        n_checks++;
        if (rd_rdy !== exp_rdy || rd_rdy_s !== exp_rdy || rd_rdy_w !== exp_rdy) begin
            n_errors++;
            $display("FAIL rd_rdy cyc %0d: got %b/%b/%b expected %b",
                     cyc, rd_rdy, rd_rdy_s, rd_rdy_w, exp_rdy);
        end
        if (rr && exp_rdy) begin
            e.e64 = m64[ra]; e.es = ms[ra]; e.ew = mw[ra]; e.cyc = cyc + 2;
            exp_q.push_back(e);
            m64[ra] = '0; ms[ra] = '0; mw[ra] = '0;
        end
        if (iv && tb_run) begin
            m64[ia] = m64[ia] + {48'b0, ival};
            ms[ia]  = sat8(ms[ia], ival[7:0]);
            mw[ia]  = mw[ia] + ival[7:0];
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        inc_vld = 1'b0; rd_req = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end
    endtask

    // Release reset, count the sweep, then check every entry reads zero.
    task automatic sweep_and_check();
        int n;
        rst = 1'b0;
        inc_vld = 1'b1; inc_addr = 4'd0; inc_val = 16'd7; rd_req = 1'b1; rd_addr = 4'd0;
        #1;
        n_checks++;
        if (rd_rdy !== 1'b0 || rd_rdy_s !== 1'b0 || rd_rdy_w !== 1'b0) begin
            n_errors++;
            $display("FAIL rdy_during_init: got %b/%b/%b expected 0", rd_rdy, rd_rdy_s, rd_rdy_w);
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (init_busy && n < 100);
        n_checks++;
        if (n != 16 || init_busy_s !== 1'b0 || init_busy_w !== 1'b0) begin
            n_errors++;
            $display("FAIL init_len: got %0d cycles (busy_s %b busy_w %b) expected 16", n, init_busy_s, init_busy_w);
        end
        inc_vld = 1'b0; rd_req = 1'b0;
        tb_run = 1'b1;
        for (int i = 0; i < 16; i++) do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'(i));
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1; tb_run = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rd_vld !== 1'b0) begin
            n_errors++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld);
        end
        n_checks++;
        if (rd_data !== 64'd0) begin
            n_errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
        end
        n_checks++;
        if (init_busy !== 1'b1 || init_busy_s !== 1'b1) begin
            n_errors++; $display("FAIL reset_init_busy: got %b/%b expected 1", init_busy, init_busy_s);
        end
        sweep_and_check();
    endtask

    task automatic test_inc_read();
        for (int i = 0; i < 4; i++) do_op(1'b1, 4'd3, 16'd5, 1'b0, 4'd0);
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd3);   // 20
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd3);   // 0 after clear
        drain();
    endtask

    task automatic test_merged();
        do_op(1'b1, 4'd7, 16'd100, 1'b0, 4'd0);
        do_op(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        do_op(1'b1, 4'd7, 16'd9, 1'b1, 4'd7);   // 100, entry becomes 9
        do_op(1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd7);   // 9
        drain();
    endtask

    task automatic test_conflict();
        do_op(1'b1, 4'd2, 16'd6, 1'b0, 4'd0);
        do_op(1'b1, 4'd1, 16'd4, 1'b1, 4'd2);   // read held off
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd2);   // accepted: 6
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd1);   // 4
        drain();
    endtask

    task automatic test_saturate();
        do_op(1'b1, 4'd4, 16'd250, 1'b0, 4'd0);
        do_op(1'b1, 4'd4, 16'd10, 1'b0, 4'd0);
        do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'd4);   // 260 / 255 / 4
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 4'($urandom_range(8, 11)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(8, 11)));
        end
        for (int i = 8; i < 12; i++) do_op(1'b0, 4'd0, 16'd0, 1'b1, 4'(i));
        drain();
    endtask

    task automatic test_rst_midop();
        do_op(1'b1, 4'd5, 16'd50, 1'b0, 4'd0);
        drain();
        // Op A enters S1 at the next edge; op B is presented with reset.
        inc_vld = 1'b1; inc_addr = 4'd5; inc_val = 16'd3; rd_req = 1'b1; rd_addr = 4'd5;
        @(posedge clk); #1;
        inc_addr = 4'd6; rd_addr = 4'd6; rst = 1'b1;
        tb_run = 1'b0;
        clear_model();
        @(posedge clk); #1;
        n_checks++;
        if (rd_vld !== 1'b0 || rd_vld_s !== 1'b0 || rd_vld_w !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_rd_vld: got %b/%b/%b expected 0", rd_vld, rd_vld_s, rd_vld_w);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rd_vld !== 1'b0 || rd_data !== 64'd0 || init_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_state: got vld %b data %0d busy %b expected 0 0 1", rd_vld, rd_data, init_busy);
        end
        sweep_and_check();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_inc_read();
        test_merged();
        test_conflict();
        test_saturate();
        test_back_to_back();
        test_rst_midop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
